// File: rtl/computie_bus_snoop_ctrl.sv
// computie_bus_snoop_ctrl: arm/trigger/stop sequencer for the bus snooper plus record-to-byte serialiser.
// Optional framing (A5 header, 5A/count trailer) is built when COMPUTIE_SNOOP_CTRL_FRAME_EN is defined.
module computie_bus_snoop_ctrl #(
  parameter int BITWIDTH    = 32,
  parameter int POST_CYCLES = 1024,
  parameter int DRAIN_IDLE  = 4,
  localparam int RW         = 2 * BITWIDTH + 1
) (
  input  logic          i_comm_clock,
  input  logic          i_comm_reset,
  input  logic          i_cmd_valid,
  input  logic [1:0]    i_cmd_op,
  output logic          o_cmd_ready,
  input  logic          i_ext_trigger,
  output logic          o_record_start,
  output logic          o_record_trigger,
  input  logic          i_record_end,
  input  logic          i_record_valid,
  output logic          o_record_ready,
  input  logic [RW-1:0] i_record_out,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [7:0]    o_out_data,
  output logic [2:0]    o_state,
  output logic [15:0]   o_rec_count
);
  // Streams: a transfer happens on a rising edge where valid and ready are both 1;
  // the source holds its payload stable while valid=1 and ready=0.
  localparam int NB  = (RW + 7) / 8;
  localparam int SW  = (NB * 8 > 24) ? NB * 8 : 24;
  localparam int PW  = $clog2(POST_CYCLES + 1);
  localparam int IW  = $clog2(DRAIN_IDLE + 1);
  localparam int BCW = $clog2(NB + 4);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARMED     = 3'd1,
    S_TRIGGERED = 3'd2,
    S_DRAIN     = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  state_e         r_state;
  state_e         w_next_state;
  logic [PW-1:0]  r_post_cnt;
  logic [IW-1:0]  r_idle_cnt;
  logic [SW-1:0]  r_shift;
  logic [BCW-1:0] r_bytes_left;
  logic [15:0]    r_rec_count;
  logic           r_cmd_ready;
  logic           w_arm;
  logic           w_trig;
  logic           w_stop;
  logic           w_empty;
  logic           w_idle_now;
  logic           w_idle_done;
  logic           w_rec_hs;
`ifdef COMPUTIE_SNOOP_CTRL_FRAME_EN
  logic           r_trl_sent;
  logic           w_drain_entry;
  logic           w_load_trailer;
`endif

  assign w_arm       = i_cmd_valid && (i_cmd_op == 2'd1);
  assign w_trig      = i_cmd_valid && (i_cmd_op == 2'd2);
  assign w_stop      = i_cmd_valid && (i_cmd_op == 2'd3);
  assign w_empty     = (r_bytes_left == '0);
  assign w_idle_now  = !i_record_valid && w_empty;
  assign w_idle_done = (r_state == S_DRAIN) && w_idle_now && (r_idle_cnt == IW'(DRAIN_IDLE - 1));
  assign w_rec_hs    = o_record_ready && i_record_valid;
`ifdef COMPUTIE_SNOOP_CTRL_FRAME_EN
  assign w_drain_entry  = (r_state != S_DRAIN) && (w_next_state == S_DRAIN);
  assign w_load_trailer = w_idle_done && !r_trl_sent;
`endif

  always_ff @(posedge i_comm_clock) begin
    if (i_comm_reset) r_state <= S_IDLE;
    else              r_state <= w_next_state;
  end

  // A stop or capture-end wins over a same-cycle trigger, so no pulse is issued then.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_arm) w_next_state = S_ARMED;
      end
      S_ARMED: begin
        if (w_stop || i_record_end)       w_next_state = S_DRAIN;
        else if (w_trig || i_ext_trigger) w_next_state = S_TRIGGERED;
      end
      S_TRIGGERED: begin
        if (w_stop || i_record_end || (r_post_cnt == PW'(1))) w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
`ifdef COMPUTIE_SNOOP_CTRL_FRAME_EN
        if (r_trl_sent && w_empty) w_next_state = S_DONE;
`else
        if (w_idle_done) w_next_state = S_DONE;
`endif
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // The post counter holds POST_CYCLES only on the first TRIGGERED cycle, which marks the pulse.
  always_comb begin
    o_record_start   = 1'b0;
    o_record_trigger = 1'b0;
    o_record_ready   = 1'b0;
    case (r_state)
      S_ARMED:     o_record_start = 1'b1;
      S_TRIGGERED: begin
        o_record_start   = 1'b1;
        o_record_trigger = (r_post_cnt == PW'(POST_CYCLES));
      end
`ifdef COMPUTIE_SNOOP_CTRL_FRAME_EN
      S_DRAIN:     o_record_ready = w_empty && !r_trl_sent;
`else
      S_DRAIN:     o_record_ready = w_empty;
`endif
      default:     ;
    endcase
  end

  always_ff @(posedge i_comm_clock) begin
    if (i_comm_reset) r_cmd_ready <= 1'b0;
    else              r_cmd_ready <= 1'b1;
  end

  always_ff @(posedge i_comm_clock) begin
    if (i_comm_reset)
      r_post_cnt <= '0;
    else if (r_state == S_ARMED && w_next_state == S_TRIGGERED)
      r_post_cnt <= PW'(POST_CYCLES);
    else if (r_state == S_TRIGGERED && r_post_cnt != '0)
      r_post_cnt <= r_post_cnt - PW'(1);
  end

  always_ff @(posedge i_comm_clock) begin
    if (i_comm_reset || r_state != S_DRAIN)
      r_idle_cnt <= '0;
`ifdef COMPUTIE_SNOOP_CTRL_FRAME_EN
    else if (r_trl_sent)
      r_idle_cnt <= r_idle_cnt;
`endif
    else if (!w_idle_now)
      r_idle_cnt <= '0;
    else if (r_idle_cnt != IW'(DRAIN_IDLE - 1))
      r_idle_cnt <= r_idle_cnt + IW'(1);
  end

`ifdef COMPUTIE_SNOOP_CTRL_FRAME_EN
  always_ff @(posedge i_comm_clock) begin
    if (i_comm_reset || r_state != S_DRAIN) r_trl_sent <= 1'b0;
    else if (w_load_trailer)                r_trl_sent <= 1'b1;
  end
`endif

  always_ff @(posedge i_comm_clock) begin
    if (i_comm_reset)
      r_rec_count <= '0;
    else if (w_arm && (r_state == S_IDLE || r_state == S_DONE))
      r_rec_count <= '0;
    else if (w_rec_hs && r_rec_count != 16'hFFFF)
      r_rec_count <= r_rec_count + 16'd1;
  end

  // Byte shifter: bytes leave from the bottom; vacated bytes fill with zero so out_data idles at 0.
  always_ff @(posedge i_comm_clock) begin
    if (i_comm_reset) begin
      r_shift      <= '0;
      r_bytes_left <= '0;
    end
`ifdef COMPUTIE_SNOOP_CTRL_FRAME_EN
    else if (w_drain_entry) begin
      r_shift      <= SW'(8'hA5);
      r_bytes_left <= BCW'(1);
    end
    else if (w_load_trailer) begin
      r_shift      <= SW'({r_rec_count, 8'h5A});
      r_bytes_left <= BCW'(3);
    end
`endif
    else if (w_rec_hs) begin
      r_shift      <= SW'(i_record_out);
      r_bytes_left <= BCW'(NB);
    end
    else if (!w_empty && i_out_ready) begin
      r_shift      <= r_shift >> 8;
      r_bytes_left <= r_bytes_left - BCW'(1);
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_out_valid = !w_empty;
  assign o_out_data  = r_shift[7:0];
  assign o_state     = r_state;
  assign o_rec_count = r_rec_count;

endmodule

// File: tb/tb_computie_bus_snoop_ctrl.sv
// Bench for computie_bus_snoop_ctrl: control vector table, then multi-cycle drain sequences against a byte queue.
// Framing expectations follow COMPUTIE_SNOOP_CTRL_FRAME_EN when it is defined.
module tb_computie_bus_snoop_ctrl;
  localparam int RW   = 65;
  localparam int NB   = 9;
  localparam int POST = 16;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic          cmd_ready;
  logic          ext_trigger;
  logic          record_start;
  logic          record_trigger;
  logic          record_end;
  logic          record_valid;
  logic          record_ready;
  logic [RW-1:0] record_out;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [2:0]    state;
  logic [15:0]   rec_count;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_bytes  = 0;
  int rdy_mode = 2;

  computie_bus_snoop_ctrl #(.BITWIDTH(32), .POST_CYCLES(POST), .DRAIN_IDLE(4)) dut (
    .i_comm_clock     (clk),
    .i_comm_reset     (rst),
    .i_cmd_valid      (cmd_valid),
    .i_cmd_op         (cmd_op),
    .o_cmd_ready      (cmd_ready),
    .i_ext_trigger    (ext_trigger),
    .o_record_start   (record_start),
    .o_record_trigger (record_trigger),
    .i_record_end     (record_end),
    .i_record_valid   (record_valid),
    .o_record_ready   (record_ready),
    .i_record_out     (record_out),
    .o_out_valid      (out_valid),
    .i_out_ready      (out_ready),
    .o_out_data       (out_data),
    .o_state          (state),
    .o_rec_count      (rec_count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // out_ready driver: 0 = always ready, 1 = toggle each cycle, 2 = held low
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0)      out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = ~out_ready;
      else                    out_ready = 1'b0;
    end
  end

  // byte monitor / scoreboard
  initial begin
    logic       stall_pending;
    logic [7:0] stall_data;
    stall_pending = 1'b0;
    stall_data    = 8'h00;
    forever begin
      @(negedge clk);
      if (stall_pending && out_valid) check("stall_hold", 32'(out_data), 32'(stall_data));
      stall_pending = 1'b0;
      if (out_valid && !out_ready) begin
        stall_pending = 1'b1;
        stall_data    = out_data;
      end
      if (out_valid && out_ready) begin
        n_bytes++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL byte_extra: got %02h, required no byte", out_data);
        end else begin
          check("byte", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic cmd(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
  endtask

  task automatic push_record(input logic [RW-1:0] r);
    logic [NB*8-1:0] v;
    v = '0;
    v[RW-1:0] = r;
    for (int b = 0; b < NB; b++) exp_q.push_back(v[b*8 +: 8]);
  endtask

  task automatic send_record(input logic [RW-1:0] r, input logic push);
    int n;
    if (push) push_record(r);
    record_out   = r;
    record_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!record_ready && n < 300);
    if (!record_ready) check("record_accept_timeout", 32'(record_ready), 32'd1);
    @(posedge clk);
    #1 record_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n;
    n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(state), 32'(s));
  endtask

  task automatic frame_head();
`ifdef COMPUTIE_SNOOP_CTRL_FRAME_EN
    exp_q.push_back(8'hA5);
`endif
  endtask

  task automatic frame_tail(input logic [15:0] cnt);
`ifdef COMPUTIE_SNOOP_CTRL_FRAME_EN
    exp_q.push_back(8'h5A);
    exp_q.push_back(cnt[7:0]);
    exp_q.push_back(cnt[15:8]);
`else
    if (cnt == 16'hFFFF) $display("note: saturated count");
`endif
  endtask

  typedef struct {
    logic       rst;
    logic       cv;
    logic [1:0] op;
    logic       ext;
    logic       rend;
    logic [2:0] st;
    logic       start;
    logic       trig;
    logic       crdy;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [7:0]    t2_bytes[9];
    logic [RW-1:0] r;
    int pulses, pulse_c, stop_c, target, n;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; ext_trigger = 1'b0;
    record_end = 1'b0; record_valid = 1'b0; record_out = '0;

    //           rst cv op    ext rend st    start trig crdy
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      rst = vecs[i].rst; cmd_valid = vecs[i].cv; cmd_op = vecs[i].op;
      ext_trigger = vecs[i].ext; record_end = vecs[i].rend;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("vec%0d_start", i), 32'(record_start), 32'(vecs[i].start));
      check($sformatf("vec%0d_trig", i), 32'(record_trigger), 32'(vecs[i].trig));
      check($sformatf("vec%0d_cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].crdy));
      if (vecs[i].rst) begin
        check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd0);
        check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'd0);
        check($sformatf("vec%0d_rec_count", i), 32'(rec_count), 32'd0);
        check($sformatf("vec%0d_rec_ready", i), 32'(record_ready), 32'd0);
      end
    end
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; ext_trigger = 1'b0; record_end = 1'b0;
    rdy_mode = 0;

    // T1: ext trigger 10 cycles after ARM, held as a level; one pulse, capture ends POST cycles later
    do_reset();
    frame_head();
    cmd(2'd1);
    pulses = 0; pulse_c = -1; stop_c = -1;
    for (int c = 0; c < 60; c++) begin
      if (c == 10) ext_trigger = 1'b1;
      if (c == 13) ext_trigger = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (record_trigger) begin
        pulses++;
        pulse_c = c;
      end
      if (pulse_c >= 0 && !record_start && stop_c < 0) stop_c = c;
    end
    check("t1_pulses", 32'(pulses), 32'd1);
    check("t1_pulse_cycle", 32'(pulse_c), 32'd10);
    check("t1_stop_gap", 32'(stop_c - pulse_c), 32'(POST));
    frame_tail(16'd0);
    wait_state(3'd4, 100, "t1_done");
    check("t1_rec_count", 32'(rec_count), 32'd0);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // T2: single known record, always-ready sink
    do_reset();
    frame_head();
    cmd(2'd1);
    cmd(2'd3);
    t2_bytes = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h78, 8'h56, 8'h34, 8'h12, 8'h01};
    for (int b = 0; b < 9; b++) exp_q.push_back(t2_bytes[b]);
    send_record({1'b1, 32'h12345678, 32'h55555555}, 1'b0);
    frame_tail(16'd1);
    wait_state(3'd4, 100, "t2_done");
    check("t2_rec_count", 32'(rec_count), 32'd1);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // T3: two random records with a sink that stalls every other cycle
    do_reset();
    rdy_mode = 1;
    frame_head();
    cmd(2'd1);
    cmd(2'd3);
    for (int k = 0; k < 2; k++) begin
      r = {1'($urandom_range(1, 0)), 32'($urandom), 32'($urandom)};
      send_record(r, 1'b1);
    end
    frame_tail(16'd2);
    wait_state(3'd4, 200, "t3_done");
    check("t3_rec_count", 32'(rec_count), 32'd2);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
    rdy_mode = 0;

    // T5: reset part-way through a record, then a clean drain
    do_reset();
    frame_head();
    cmd(2'd1);
    cmd(2'd3);
`ifdef COMPUTIE_SNOOP_CTRL_FRAME_EN
    target = n_bytes + 5;
`else
    target = n_bytes + 4;
`endif
    send_record({1'b0, 32'hDEADBEEF, 32'hCAFEF00D}, 1'b1);
    n = 0;
    while (n_bytes < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_bytes_before_reset", 32'(n_bytes >= target), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rdy_mode = 2;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_out_valid_after_reset", 32'(out_valid), 32'd0);
    check("t5_state_after_reset", 32'(state), 32'd0);
    check("t5_out_data_after_reset", 32'(out_data), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    rdy_mode = 0;
    frame_head();
    cmd(2'd1);
    cmd(2'd3);
    send_record({1'b1, 32'h0BADF00D, 32'h13579BDF}, 1'b1);
    frame_tail(16'd1);
    wait_state(3'd4, 100, "t5_done");
    check("t5_rec_count", 32'(rec_count), 32'd1);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // T6: re-ARM straight from DONE, three records
    frame_head();
    cmd(2'd1);
    check("t6_rec_count_cleared", 32'(rec_count), 32'd0);
    check("t6_state_armed", 32'(state), 32'd1);
    cmd(2'd3);
    for (int k = 0; k < 3; k++) begin
      r = {1'(k[0]), 32'($urandom), 32'($urandom)};
      send_record(r, 1'b1);
    end
    frame_tail(16'd3);
    wait_state(3'd4, 200, "t6_done");
    check("t6_rec_count", 32'(rec_count), 32'd3);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t6_out_valid_idle", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
